axi3_ram_slave: RTL and testbench
=================================

Name: axi3_ram_slave

Overview:
- AXI3 slave memory that terminates the `axi3_if` bus on its slave modport.
- Downstream endpoint for any AXI3 master in the design: serves write and read bursts from an internal byte-addressable word RAM.
- Read and write paths are independent; each path has one outstanding transaction.
- Used as the default memory target in system benches and small SoC builds.

Parameters:
- DATA_BYTES, 4: bus data width in bytes; must be a power of 2.
- ADDR_BYTES, 4: address width in bytes.
- NUM_ID_BITS_P, 4: AXI ID width.
- DEPTH_WORDS, 256: RAM depth in DATA_BYTES-wide words; must be a power of 2.

Ports:
- aclk  input  1  clock; single clock domain.
- areset  input  1  reset; synchronous, active-high.
- s_axi  interface  axi3_if.slave  AXI3 bus, all five channels. The interface's own aclk/aresetn are not used by this block.

Behaviour:
- Reset: all FSMs go to IDLE. awready=1, aready=1. wready=0, bwvalid=0, rvalid=0, rlast=0. bresp/rresp/bid/rid/rdata=0. RAM contents are retained.
- Word index = addr >> log2(DATA_BYTES). A beat is in range if word index < DEPTH_WORDS.
- Transaction legality:
  - burst 2'b00 (FIXED) and 2'b01 (INCR) are supported.
  - WRAP and reserved burst types are illegal.
  - size != log2(DATA_BYTES) is illegal.
- Error responses:
  - An illegal transaction still completes all len+1 beats.
  - Every beat of an illegal transaction gets SLVERR (2'b10). No RAM writes occur; rdata=0.
  - In a legal transaction, any out-of-range beat gets SLVERR with no write and rdata=0.
- Address stepping: INCR adds DATA_BYTES per beat and never wraps. FIXED repeats the same address every beat.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&&awready, latch awaddr, awlen, awid, legality; clear the beat count; go to W_DATA.
  - W_DATA: wready=1. On each wvalid&&wready, write bytes where wstrb[i]=1 (if the beat is legal and in range), then advance the address.
  - Sticky error flag is set by: wid != latched awid, wlast asserted on a non-final beat, or wlast low on the final beat.
  - After beat len+1, go to W_RESP. The beat count, not wlast, ends the burst.
  - W_RESP: bwvalid=1; bid=awid; bresp=2'b10 if any beat errored, else 2'b00. Hold until bwready, then go to W_IDLE.
  - Next awready is the cycle after the B handshake.
- Read FSM:
  - R_IDLE: aready=1. On arvalid&&aready, latch the request, issue the RAM read for beat 0, go to R_DATA.
  - R_DATA: rvalid=1. rid=arid; rresp is per beat; rlast=1 on beat len.
  - Read latency: rvalid rises the cycle after the AR handshake.
  - On rvalid&&rready, advance the address and read the next word. rdata is stable while rready=0.
  - After the last handshake, go to R_IDLE with rvalid=0.
- Same-cycle write and read to the same word: the read returns the old data.
- Reset mid-burst: the transaction is abandoned. No B or R is issued for it. Writes already performed remain.
- Beat counter is 4 bits and compares against len (0..15).

Optional Feature:
- Macro: AXI3_RAM_RDATA_REG_EN.
- Defined: adds an output register on the RAM read path.
  - First rvalid comes 2 cycles after the AR handshake.
  - Each following beat has a 1-cycle bubble after its handshake, since the prefetch is not pipelined.
  - Read responses are otherwise identical.
- Undefined: behaviour as specified above (1-cycle latency, full throughput).

Decomposition:
- axi3_pkg holds:
  - burst_t enum: FIXED, INCR, WRAP, RSVD.
  - resp constants: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Write and read FSM state enums.
- Sub-module axi3_ram_mem: simple dual-port RAM with one write port (per-byte enable) and one synchronous read port with read enable.

Test Plan:
- INCR write: awaddr=0x10, awlen=3, wdata 0xA0..0xA3, wstrb=4'hF -> bresp=00. Then INCR read of the same range -> rdata 0xA0..0xA3, rlast on beat 3, rresp=00.
- Strobed write: wstrb=4'b0101, wdata=0xFFFFFFFF over a word holding 0x12345678 -> readback 0x12FF56FF.
- FIXED read: len=2 at 0x20 -> three beats of the same word. WRAP write -> bresp=10 and memory unchanged.
- Out of range (DEPTH=256): INCR read at addr 0x3FC, len=1 -> beat0 rresp=00, beat1 rresp=10 with rdata=0.
- Protocol error: wid != awid, or wlast on beat 1 of 4 -> still 4 wready beats, then bresp=10. Backpressure: hold rready=0 for 5 cycles -> rdata/rvalid/rlast stable.
- Reset mid-burst: assert areset during write beat 2 of 4 -> next cycle awready=1 and bwvalid=0. Beats 0-1 are written; a new burst completes normally.

Source files
------------

// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - shared AXI3 burst/response types and RAM slave FSM states
//
// Purpose : common definitions for the AXI3 RAM slave and its helpers.
// Contents: burst_t, AXI response codes, write/read FSM state enums and a
//           burst-type legality helper.
package axi3_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wstate_t;

  // R_WAIT is only entered when the registered read path is built in.
  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_WAIT = 2'b01,
    R_DATA = 2'b10
  } rstate_t;

  // Only FIXED and INCR bursts are served; WRAP and the reserved code are not.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == FIXED) || (burst == INCR);
  endfunction

endpackage

// File: rtl/axi3_if.sv
// rtl/axi3_if.sv - AXI3 bus bundle with master and slave modports
//
// Purpose : carries the five AXI3 channels between a master and a slave.
// Ports   : aclk    - bus clock (informational for endpoints with own clock)
//           aresetn - bus reset, active-low (informational, see above)
// Channels: AW (awid/awaddr/awlen/awsize/awburst/awvalid/awready)
//           W  (wid/wdata/wstrb/wlast/wvalid/wready)
//           B  (bid/bresp/bwvalid/bwready)
//           AR (arid/araddr/arlen/arsize/arburst/arvalid/aready)
//           R  (rid/rdata/rresp/rlast/rvalid/rready)
interface axi3_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 4,
  parameter int ID_BITS    = 4
) (
  input logic aclk,
  input logic aresetn
);

  logic [ID_BITS-1:0]      awid;
  logic [ADDR_BYTES*8-1:0] awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [ID_BITS-1:0]      wid;
  logic [DATA_BYTES*8-1:0] wdata;
  logic [DATA_BYTES-1:0]   wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_BITS-1:0]      bid;
  logic [1:0]              bresp;
  logic                    bwvalid;
  logic                    bwready;

  logic [ID_BITS-1:0]      arid;
  logic [ADDR_BYTES*8-1:0] araddr;
  logic [3:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    aready;

  logic [ID_BITS-1:0]      rid;
  logic [DATA_BYTES*8-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  aclk, aresetn,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bwvalid,
    input  bwready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output aready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    input  aclk, aresetn,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bwvalid,
    output bwready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  aready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi3_ram_mem.sv
// rtl/axi3_ram_mem.sv - simple dual-port word RAM with byte write enables
//
// Purpose : storage array behind the AXI3 RAM slave.
// Ports   : clk     - clock
//           wr_be   - per-byte write enable (no write when all zero)
//           wr_addr - write word index
//           wr_data - write data
//           rd_en   - read enable; rd_data only changes on an enabled read
//           rd_addr - read word index
//           rd_data - registered read data (old contents on same-word write)
module axi3_ram_mem #(
  parameter int DATA_BYTES  = 4,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic [DATA_BYTES-1:0]          wr_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
  input  logic [DATA_BYTES*8-1:0]        wr_data,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
  output logic [DATA_BYTES*8-1:0]        rd_data
);

  logic [DATA_BYTES*8-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Holding rd_data when rd_en is low is what keeps R-channel data stable
  // under backpressure.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi3_ram_slave.sv
// rtl/axi3_ram_slave.sv - AXI3 slave serving bursts from an internal word RAM
//
// Purpose : terminates an AXI3 bus; one outstanding write and one outstanding
//           read, handled by independent FSMs. FIXED/INCR bursts of full bus
//           width are served; anything else completes with SLVERR on every
//           beat and never touches the RAM.
// Ports   : aclk   - clock
//           areset - synchronous active-high reset (RAM contents retained)
//           s_axi  - axi3_if.slave, all five channels (its aclk/aresetn unused)
// Options : AXI3_RAM_RDATA_REG_EN - adds an output register on the RAM read
//           path (2-cycle first-beat latency, one bubble between beats).
module axi3_ram_slave
  import axi3_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDR_BYTES    = 4,
  parameter int NUM_ID_BITS_P = 4,
  parameter int DEPTH_WORDS   = 256
) (
  input  logic  aclk,
  input  logic  areset,
  axi3_if.slave s_axi
);

  localparam int AW_BITS  = ADDR_BYTES * 8;
  localparam int DW_BITS  = DATA_BYTES * 8;
  localparam int SHIFT    = $clog2(DATA_BYTES);
  localparam int IDX_BITS = $clog2(DEPTH_WORDS);
  localparam logic [2:0]         BEAT_SIZE = 3'(SHIFT);
  localparam logic [AW_BITS-1:0] STEP      = AW_BITS'(DATA_BYTES);

`ifdef AXI3_RAM_RDATA_REG_EN
  localparam rstate_t FETCH_STATE = R_WAIT;
`else
  localparam rstate_t FETCH_STATE = R_DATA;
`endif

  function automatic logic in_range(input logic [AW_BITS-1:0] addr);
    return (addr >> SHIFT) < AW_BITS'(DEPTH_WORDS);
  endfunction

  function automatic logic [AW_BITS-1:0] step_addr(input logic [AW_BITS-1:0] addr,
                                                   input burst_t             burst);
    return (burst == INCR) ? addr + STEP : addr;
  endfunction

  // ---------------------------------------------------------------- write
  wstate_t                w_state, w_state_nx;
  logic [AW_BITS-1:0]     w_addr;
  logic [3:0]             w_len, w_beat;
  logic [NUM_ID_BITS_P-1:0] w_id;
  burst_t                 w_burst;
  logic                   w_legal, w_err;
  logic                   aw_ready_c, w_ready_c, b_valid_c;
  logic                   aw_hs, w_hs, w_final, w_beat_ok, aw_legal;
  logic [DATA_BYTES-1:0]  mem_wr_be;

  assign aw_legal  = burst_supported(s_axi.awburst) && (s_axi.awsize == BEAT_SIZE);
  assign w_final   = (w_beat == w_len);
  assign w_beat_ok = w_legal && in_range(w_addr);
  assign aw_hs     = aw_ready_c && s_axi.awvalid;
  assign w_hs      = w_ready_c && s_axi.wvalid;

  always_comb begin
    w_state_nx = w_state;
    aw_ready_c = 1'b0;
    w_ready_c  = 1'b0;
    b_valid_c  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready_c = 1'b1;
        if (s_axi.awvalid) w_state_nx = W_DATA;
      end
      W_DATA: begin
        w_ready_c = 1'b1;
        // The beat count closes the burst; wlast only feeds the error flag.
        if (s_axi.wvalid && w_final) w_state_nx = W_RESP;
      end
      W_RESP: begin
        b_valid_c = 1'b1;
        if (s_axi.bwready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_id    <= '0;
      w_burst <= FIXED;
      w_legal <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      if (aw_hs) begin
        w_addr  <= s_axi.awaddr;
        w_len   <= s_axi.awlen;
        w_id    <= s_axi.awid;
        w_burst <= burst_t'(s_axi.awburst);
        w_legal <= aw_legal;
        w_beat  <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_beat <= w_beat + 4'd1;
        w_addr <= step_addr(w_addr, w_burst);
        if (!w_beat_ok || (s_axi.wid != w_id) || (s_axi.wlast != w_final)) begin
          w_err <= 1'b1;
        end
      end
    end
  end

  // A beat presented in the reset cycle belongs to the abandoned burst.
  assign mem_wr_be = (w_hs && w_beat_ok && !areset) ? s_axi.wstrb : '0;

  assign s_axi.awready = aw_ready_c;
  assign s_axi.wready  = w_ready_c;
  assign s_axi.bwvalid = b_valid_c;
  assign s_axi.bid     = b_valid_c ? w_id : '0;
  assign s_axi.bresp   = (b_valid_c && w_err) ? RESP_SLVERR : RESP_OKAY;

  // ----------------------------------------------------------------- read
  rstate_t                r_state, r_state_nx;
  logic [AW_BITS-1:0]     r_addr, r_addr_step, rd_addr;
  logic [3:0]             r_len, r_beat;
  logic [NUM_ID_BITS_P-1:0] r_id;
  burst_t                 r_burst;
  logic                   r_legal, r_err, r_last;
  logic                   ar_ready_c, r_valid_c, ar_hs, r_hs, ar_legal;
  logic                   rd_legal, rd_err, mem_rd_en;
  logic [DW_BITS-1:0]     mem_rd_data, r_data_src;

  assign ar_legal    = burst_supported(s_axi.arburst) && (s_axi.arsize == BEAT_SIZE);
  assign r_addr_step = step_addr(r_addr, r_burst);
  assign r_last      = (r_beat == r_len);
  assign ar_hs       = ar_ready_c && s_axi.arvalid;
  assign r_hs        = r_valid_c && s_axi.rready;
  // Error status of the beat being fetched; it travels with the RAM data.
  assign rd_err      = !rd_legal || !in_range(rd_addr);

  always_comb begin
    r_state_nx = r_state;
    ar_ready_c = 1'b0;
    r_valid_c  = 1'b0;
    mem_rd_en  = 1'b0;
    rd_addr    = r_addr_step;
    rd_legal   = r_legal;
    case (r_state)
      R_IDLE: begin
        ar_ready_c = 1'b1;
        rd_addr    = s_axi.araddr;
        rd_legal   = ar_legal;
        if (s_axi.arvalid) begin
          mem_rd_en  = 1'b1;
          r_state_nx = FETCH_STATE;
        end
      end
      R_WAIT: r_state_nx = R_DATA;
      R_DATA: begin
        r_valid_c = 1'b1;
        if (s_axi.rready) begin
          if (r_last) begin
            r_state_nx = R_IDLE;
          end else begin
            mem_rd_en  = 1'b1;
            r_state_nx = FETCH_STATE;
          end
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_id    <= '0;
      r_burst <= FIXED;
      r_legal <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      if (ar_hs) begin
        r_addr  <= s_axi.araddr;
        r_len   <= s_axi.arlen;
        r_id    <= s_axi.arid;
        r_burst <= burst_t'(s_axi.arburst);
        r_legal <= ar_legal;
        r_beat  <= '0;
        r_err   <= rd_err;
      end else if (r_hs && !r_last) begin
        r_addr <= r_addr_step;
        r_beat <= r_beat + 4'd1;
        r_err  <= rd_err;
      end
    end
  end

`ifdef AXI3_RAM_RDATA_REG_EN
  logic [DW_BITS-1:0] rdata_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata_q <= '0;
    end else if (r_state == R_WAIT) begin
      rdata_q <= mem_rd_data;
    end
  end

  assign r_data_src = rdata_q;
`else
  assign r_data_src = mem_rd_data;
`endif

  assign s_axi.aready = ar_ready_c;
  assign s_axi.rvalid = r_valid_c;
  assign s_axi.rlast  = r_valid_c && r_last;
  assign s_axi.rid    = r_valid_c ? r_id : '0;
  assign s_axi.rresp  = (r_valid_c && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rdata  = (r_valid_c && !r_err) ? r_data_src : '0;

  // ------------------------------------------------------------------ RAM
  axi3_ram_mem #(
    .DATA_BYTES (DATA_BYTES),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk    (aclk),
    .wr_be  (mem_wr_be),
    .wr_addr(w_addr[SHIFT +: IDX_BITS]),
    .wr_data(s_axi.wdata),
    .rd_en  (mem_rd_en),
    .rd_addr(rd_addr[SHIFT +: IDX_BITS]),
    .rd_data(mem_rd_data)
  );

endmodule

// File: tb/tb_axi3_ram_slave.sv
// tb/tb_axi3_ram_slave.sv - directed scoreboard bench for axi3_ram_slave
module tb_axi3_ram_slave;

  logic clk = 1'b0;
  logic areset;

  always #5 clk = ~clk;

  axi3_if #(.DATA_BYTES(4), .ADDR_BYTES(4), .ID_BITS(4)) bus (.aclk(clk), .aresetn(~areset));

  axi3_ram_slave #(
    .DATA_BYTES   (4),
    .ADDR_BYTES   (4),
    .NUM_ID_BITS_P(4),
    .DEPTH_WORDS  (256)
  ) dut (
    .aclk  (clk),
    .areset(areset),
    .s_axi (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  localparam int TMO = 100;
`ifdef AXI3_RAM_RDATA_REG_EN
  localparam logic FIRST_VALID = 1'b0;
`else
  localparam logic FIRST_VALID = 1'b1;
`endif

  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [31:0] mdl [256];
  logic [31:0] wb_data [16];
  logic [3:0]  wb_strb [16];
  logic [3:0]  wb_id   [16];
  logic        wb_last [16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic beat_ok(input logic [31:0] addr, input logic [1:0] burst,
                                   input logic [2:0] size);
    return ((burst == 2'b00) || (burst == 2'b01)) && (size == 3'd2) && (addr < 32'h400);
  endfunction

  task automatic fill_wbeats(input logic [31:0] base, input logic [3:0] strb,
                             input logic [3:0] id, input logic [3:0] len);
    for (int i = 0; i < 16; i++) begin
      wb_data[i] = base + 32'(i);
      wb_strb[i] = strb;
      wb_id[i]   = id;
      wb_last[i] = (i == int'(len));
    end
  endtask

  task automatic b_recv();
    bexp_t e;
    int    to;
    bus.bwready = 1'b1;
    to = 0;
    while (!bus.bwvalid && to < TMO) begin @(negedge clk); to++; end
    chk("b_timeout", 32'(to < TMO), 32'd1);
    e = exp_b.pop_front();
    chk("bresp", 32'(bus.bresp), 32'(e.resp));
    chk("bid", 32'(bus.bid), 32'(e.id));
    @(negedge clk);
    bus.bwready = 1'b0;
  endtask

  // abort_at >= 0 asserts reset together with that beat and abandons the burst.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [3:0] id, input logic [1:0] burst,
                             input logic [2:0] size, input int abort_at);
    logic [31:0] a;
    logic        err;
    int          to;
    a   = addr;
    err = 1'b0;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awid    = id;
    bus.awburst = burst;
    bus.awsize  = size;
    bus.awvalid = 1'b1;
    to = 0;
    while (!bus.awready && to < TMO) begin @(negedge clk); to++; end
    chk("aw_timeout", 32'(to < TMO), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata  = wb_data[i];
      bus.wstrb  = wb_strb[i];
      bus.wid    = wb_id[i];
      bus.wlast  = wb_last[i];
      bus.wvalid = 1'b1;
      if (i == abort_at) begin
        areset = 1'b1;
        @(negedge clk);
        areset     = 1'b0;
        bus.wvalid = 1'b0;
        return;
      end
      chk("b_before_last", 32'(bus.bwvalid), 32'd0);
      to = 0;
      while (!bus.wready && to < TMO) begin @(negedge clk); to++; end
      chk("w_timeout", 32'(to < TMO), 32'd1);
      @(negedge clk);
      bus.wvalid = 1'b0;
      if (beat_ok(a, burst, size)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_strb[i][b]) mdl[a[9:2]][b*8 +: 8] = wb_data[i][b*8 +: 8];
        end
      end else begin
        err = 1'b1;
      end
      if ((wb_id[i] != id) || (wb_last[i] != (i == int'(len)))) err = 1'b1;
      if (burst == 2'b01) a = a + 32'd4;
    end
    exp_b.push_back('{resp: (err ? 2'b10 : 2'b00), id: id});
    b_recv();
  endtask

  task automatic read_issue(input logic [31:0] addr, input logic [3:0] len,
                            input logic [3:0] id, input logic [1:0] burst,
                            input logic [2:0] size);
    logic [31:0] a;
    logic        ok;
    int          to;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      ok = beat_ok(a, burst, size);
      exp_r.push_back('{data: (ok ? mdl[a[9:2]] : 32'h0), resp: (ok ? 2'b00 : 2'b10),
                        last: (i == int'(len)), id: id});
      if (burst == 2'b01) a = a + 32'd4;
    end
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arid    = id;
    bus.arburst = burst;
    bus.arsize  = size;
    bus.arvalid = 1'b1;
    to = 0;
    while (!bus.aready && to < TMO) begin @(negedge clk); to++; end
    chk("ar_timeout", 32'(to < TMO), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_collect(input int n);
    rbeat_t e;
    int     to;
    bus.rready = 1'b1;
    for (int i = 0; i < n; i++) begin
      to = 0;
      while (!bus.rvalid && to < TMO) begin @(negedge clk); to++; end
      chk("r_timeout", 32'(to < TMO), 32'd1);
      e = exp_r.pop_front();
      chk("rdata", bus.rdata, e.data);
      chk("rresp", 32'(bus.rresp), 32'(e.resp));
      chk("rlast", 32'(bus.rlast), 32'(e.last));
      chk("rid", 32'(bus.rid), 32'(e.id));
      @(negedge clk);
    end
    bus.rready = 1'b0;
    chk("r_idle_after_last", 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    int to;
    areset      = 1'b1;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awid = '0;
    bus.awsize  = 3'd2; bus.awburst = 2'b01;
    bus.wvalid  = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wid = '0; bus.wlast = 1'b0;
    bus.bwready = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arid = '0;
    bus.arsize  = 3'd2; bus.arburst = 2'b01;
    bus.rready  = 1'b0;
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    areset = 1'b0;

    // Reset state
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_aready", 32'(bus.aready), 32'd1);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bwvalid", 32'(bus.bwvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_bresp", 32'(bus.bresp), 32'd0);
    chk("rst_rresp", 32'(bus.rresp), 32'd0);
    chk("rst_bid", 32'(bus.bid), 32'd0);
    chk("rst_rid", 32'(bus.rid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);

    // INCR write then read back, with first-beat latency check
    fill_wbeats(32'hA0, 4'hF, 4'd5, 4'd3);
    write_burst(32'h10, 4'd3, 4'd5, 2'b01, 3'd2, -1);
    read_issue(32'h10, 4'd3, 4'd3, 2'b01, 3'd2);
    chk("r_first_latency", 32'(bus.rvalid), 32'(FIRST_VALID));
    r_collect(4);

    // Strobed write over a known word
    fill_wbeats(32'h12345678, 4'hF, 4'd1, 4'd0);
    write_burst(32'h40, 4'd0, 4'd1, 2'b01, 3'd2, -1);
    fill_wbeats(32'hFFFFFFFF, 4'b0101, 4'd1, 4'd0);
    write_burst(32'h40, 4'd0, 4'd1, 2'b01, 3'd2, -1);
    read_issue(32'h40, 4'd0, 4'd1, 2'b01, 3'd2);
    r_collect(1);

    // FIXED read repeats one word
    fill_wbeats(32'hCAFEF00D, 4'hF, 4'd1, 4'd0);
    write_burst(32'h20, 4'd0, 4'd1, 2'b01, 3'd2, -1);
    read_issue(32'h20, 4'd2, 4'd9, 2'b00, 3'd2);
    r_collect(3);

    // WRAP write is rejected and leaves memory unchanged
    fill_wbeats(32'hDEAD0000, 4'hF, 4'd2, 4'd1);
    write_burst(32'h20, 4'd1, 4'd2, 2'b10, 3'd2, -1);
    read_issue(32'h20, 4'd0, 4'd2, 2'b01, 3'd2);
    r_collect(1);

    // Last in-range word followed by an out-of-range beat
    fill_wbeats(32'h55AA55AA, 4'hF, 4'd3, 4'd0);
    write_burst(32'h3FC, 4'd0, 4'd3, 2'b01, 3'd2, -1);
    read_issue(32'h3FC, 4'd1, 4'd3, 2'b01, 3'd2);
    r_collect(2);

    // Narrow size is illegal on read
    read_issue(32'h10, 4'd1, 4'd4, 2'b01, 3'd1);
    r_collect(2);

    // Protocol errors: wrong wid, early wlast
    fill_wbeats(32'h80000000, 4'hF, 4'd2, 4'd3);
    wb_id[2] = 4'd7;
    write_burst(32'h80, 4'd3, 4'd2, 2'b01, 3'd2, -1);
    fill_wbeats(32'h90000000, 4'hF, 4'd8, 4'd3);
    wb_last[1] = 1'b1;
    write_burst(32'h90, 4'd3, 4'd8, 2'b01, 3'd2, -1);

    // Read backpressure keeps the beat stable
    read_issue(32'h10, 4'd1, 4'd6, 2'b01, 3'd2);
    to = 0;
    while (!bus.rvalid && to < TMO) begin @(negedge clk); to++; end
    chk("bp_timeout", 32'(to < TMO), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", 32'(bus.rvalid), 32'd1);
      chk("bp_rdata", bus.rdata, exp_r[0].data);
      chk("bp_rlast", 32'(bus.rlast), 32'(exp_r[0].last));
      @(negedge clk);
    end
    r_collect(2);

    // Reset during beat 2 of 4
    fill_wbeats(32'hB0, 4'hF, 4'd6, 4'd3);
    write_burst(32'h100, 4'd3, 4'd6, 2'b01, 3'd2, 2);
    chk("abort_awready", 32'(bus.awready), 32'd1);
    chk("abort_bwvalid", 32'(bus.bwvalid), 32'd0);
    chk("abort_wready", 32'(bus.wready), 32'd0);
    read_issue(32'h100, 4'd1, 4'd6, 2'b01, 3'd2);
    r_collect(2);
    fill_wbeats(32'hC0, 4'hF, 4'd7, 4'd3);
    write_burst(32'h100, 4'd3, 4'd7, 2'b01, 3'd2, -1);
    read_issue(32'h100, 4'd3, 4'd7, 2'b01, 3'd2);
    r_collect(4);

    chk("scoreboard_r_empty", 32'(exp_r.size()), 32'd0);
    chk("scoreboard_b_empty", 32'(exp_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
